// File: rtl/control_pipe.sv
// control_pipe: single-entry decode -> execute control stage.
// Decodes the opcode into execute controls, stalls one cycle on a
// load-use hazard and discards incoming instructions for FLUSH_CYC
// cycles after a taken branch.
// Optional feature macro: VECTOR_OP_EN (adds opcode 1010111 as a
// legal vector op writing a register).
module control_pipe #(
    parameter int FLUSH_CYC = 2,
    parameter int REG_W     = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    // decode-side handshake and instruction fields
    input  logic             inst_valid_i,
    output logic             inst_ready_o,
    input  logic [6:0]       op_i,
    input  logic [REG_W-1:0] rs1_i,
    input  logic [REG_W-1:0] rs2_i,
    input  logic [REG_W-1:0] rd_i,
    // execute-side handshake and registered controls
    output logic             ex_valid_o,
    input  logic             ex_ready_i,
    output logic [1:0]       alu_op_o,
    output logic             alu_src_o,
    output logic             reg_write_o,
    output logic             mem_rd_o,
    output logic             mem_wr_o,
    output logic             mem_to_reg_o,
    output logic             branch_o,
    output logic             imm_sel_o,
    output logic             illegal_o,
    output logic [REG_W-1:0] rd_o,
    // branch resolution from EX
    input  logic             br_resolve_i,
    input  logic             br_taken_i,
    output logic             flush_busy_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // decoded fields for the instruction currently presented
    logic [1:0] dec_alu_op;
    logic       dec_alu_src;
    logic       dec_reg_write;
    logic       dec_mem_rd;
    logic       dec_mem_wr;
    logic       dec_mem_to_reg;
    logic       dec_branch;
    logic       dec_imm_sel;
    logic       dec_illegal;
    logic       uses_rs2;

    logic hazard;
    logic accept;
    logic flush_req;

    // opcode decode; unknown opcodes fall through to the illegal default
    always_comb begin
        dec_alu_op     = 2'b11;
        dec_alu_src    = 1'b1;
        dec_reg_write  = 1'b0;
        dec_mem_rd     = 1'b0;
        dec_mem_wr     = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_branch     = 1'b0;
        dec_imm_sel    = 1'b0;
        dec_illegal    = 1'b1;
        uses_rs2       = 1'b0;
        case (op_i)
            7'b0010011: begin
                dec_alu_op    = 2'b11;
                dec_reg_write = 1'b1;
                dec_illegal   = 1'b0;
            end
            7'b0110011: begin
                dec_alu_op    = 2'b10;
                dec_alu_src   = 1'b0;
                dec_reg_write = 1'b1;
                dec_illegal   = 1'b0;
                uses_rs2      = 1'b1;
            end
            7'b1100011: begin
                dec_alu_op  = 2'b01;
                dec_branch  = 1'b1;
                dec_illegal = 1'b0;
                uses_rs2    = 1'b1;
            end
            7'b0000011: begin
                dec_alu_op     = 2'b00;
                dec_reg_write  = 1'b1;
                dec_mem_rd     = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_illegal    = 1'b0;
            end
            7'b0100011: begin
                dec_alu_op  = 2'b00;
                dec_mem_wr  = 1'b1;
                dec_imm_sel = 1'b1;
                dec_illegal = 1'b0;
                uses_rs2    = 1'b1;
            end
`ifdef VECTOR_OP_EN
            7'b1010111: begin
                dec_alu_op    = 2'b00;
                dec_alu_src   = 1'b0;
                dec_reg_write = 1'b1;
                dec_illegal   = 1'b0;
            end
`else
            // without vector support 1010111 is just another illegal opcode
`endif
            default: ;
        endcase
    end

    // load in EX whose destination feeds the presented instruction; x0 never hazards
    always_comb begin
        hazard = ex_valid_o && mem_rd_o && (rd_o != '0) &&
                 ((rs1_i == rd_o) || (uses_rs2 && (rs2_i == rd_o)));
    end

    // FLUSH swallows everything; RUN accepts when the output slot frees up
    always_comb begin
        inst_ready_o = (state_q == FLUSH) ||
                       ((state_q == RUN) && !hazard && (!ex_valid_o || ex_ready_i));
        accept       = inst_valid_i && inst_ready_o;
        flush_req    = br_resolve_i && br_taken_i;
        flush_busy_o = (state_q == FLUSH);
    end

    // state and flush counter registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state: a taken branch wins over stall, accept and an ongoing flush
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_req) begin
            state_d = FLUSH;
            cnt_d   = 4'(FLUSH_CYC - 1);
        end else begin
            case (state_q)
                RUN: begin
                    if (inst_valid_i && hazard && ex_ready_i)
                        state_d = STALL;
                end
                STALL: state_d = RUN;
                FLUSH: begin
                    if (cnt_q == 4'd0)
                        state_d = RUN;
                    else
                        cnt_d = cnt_q - 4'd1;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // output register: load on RUN accept, drain on ex_ready, kill on flush
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_valid_o   <= 1'b0;
            alu_op_o     <= '0;
            alu_src_o    <= 1'b0;
            reg_write_o  <= 1'b0;
            mem_rd_o     <= 1'b0;
            mem_wr_o     <= 1'b0;
            mem_to_reg_o <= 1'b0;
            branch_o     <= 1'b0;
            imm_sel_o    <= 1'b0;
            illegal_o    <= 1'b0;
            rd_o         <= '0;
        end else if (flush_req) begin
            ex_valid_o <= 1'b0;
        end else if ((state_q == RUN) && accept) begin
            ex_valid_o   <= 1'b1;
            alu_op_o     <= dec_alu_op;
            alu_src_o    <= dec_alu_src;
            reg_write_o  <= dec_reg_write;
            mem_rd_o     <= dec_mem_rd;
            mem_wr_o     <= dec_mem_wr;
            mem_to_reg_o <= dec_mem_to_reg;
            branch_o     <= dec_branch;
            imm_sel_o    <= dec_imm_sel;
            illegal_o    <= dec_illegal;
            rd_o         <= rd_i;
        end else if (ex_ready_i) begin
            ex_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed vectors with hand-computed expectations.
module tb_control_pipe;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       inst_valid_i;
    logic       inst_ready_o;
    logic [6:0] op_i;
    logic [4:0] rs1_i, rs2_i, rd_i;
    logic       ex_valid_o;
    logic       ex_ready_i;
    logic [1:0] alu_op_o;
    logic       alu_src_o, reg_write_o, mem_rd_o, mem_wr_o, mem_to_reg_o;
    logic       branch_o, imm_sel_o, illegal_o;
    logic [4:0] rd_o;
    logic       br_resolve_i, br_taken_i;
    logic       flush_busy_o;

    int n_chk = 0;
    int n_err = 0;

    control_pipe #(.FLUSH_CYC(2), .REG_W(5)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
        .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .alu_op_o(alu_op_o), .alu_src_o(alu_src_o), .reg_write_o(reg_write_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_to_reg_o(mem_to_reg_o),
        .branch_o(branch_o), .imm_sel_o(imm_sel_o), .illegal_o(illegal_o),
        .rd_o(rd_o),
        .br_resolve_i(br_resolve_i), .br_taken_i(br_taken_i),
        .flush_busy_o(flush_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one rising edge and sample 1ns later
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic present(input logic [6:0] op, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd);
        inst_valid_i = 1'b1;
        op_i  = op;
        rs1_i = rs1;
        rs2_i = rs2;
        rd_i  = rd;
        #1;
    endtask

    initial begin
        rst_n_i = 1'b0; inst_valid_i = 1'b0; op_i = '0;
        rs1_i = '0; rs2_i = '0; rd_i = '0;
        ex_ready_i = 1'b1; br_resolve_i = 1'b0; br_taken_i = 1'b0;
        #2;
        check("rst_ex_valid", 32'(ex_valid_o), 0);
        check("rst_flush_busy", 32'(flush_busy_o), 0);
        check("rst_rd", 32'(rd_o), 0);
        check("rst_alu_op", 32'(alu_op_o), 0);
        check("rst_alu_src", 32'(alu_src_o), 0);
        repeat (2) tick();
        rst_n_i = 1'b1;
        #1;
        check("rst_ready", 32'(inst_ready_o), 1);

        // load rd=3 accepted, latency 1
        present(7'b0000011, 5'd1, 5'd2, 5'd3);
        check("lw_ready", 32'(inst_ready_o), 1);
        tick();
        check("lw_valid", 32'(ex_valid_o), 1);
        check("lw_mem_rd", 32'(mem_rd_o), 1);
        check("lw_mem_to_reg", 32'(mem_to_reg_o), 1);
        check("lw_reg_write", 32'(reg_write_o), 1);
        check("lw_alu_op", 32'(alu_op_o), 0);
        check("lw_alu_src", 32'(alu_src_o), 1);
        check("lw_rd", 32'(rd_o), 3);
        check("lw_illegal", 32'(illegal_o), 0);

        // load-use through rs2 -> stall one cycle, bubble, then accept
        present(7'b0110011, 5'd1, 5'd3, 5'd5);
        check("hz_ready", 32'(inst_ready_o), 0);
        tick();
        check("hz_bubble", 32'(ex_valid_o), 0);
        check("hz_stall_ready", 32'(inst_ready_o), 0);
        tick();
        check("hz_run_valid", 32'(ex_valid_o), 0);
        check("hz_run_ready", 32'(inst_ready_o), 1);
        tick();
        check("add_valid", 32'(ex_valid_o), 1);
        check("add_alu_op", 32'(alu_op_o), 2);
        check("add_alu_src", 32'(alu_src_o), 0);
        check("add_mem_rd", 32'(mem_rd_o), 0);
        check("add_rd", 32'(rd_o), 5);

        // back-pressure: outputs hold and ready stays low
        ex_ready_i = 1'b0;
        present(7'b0010011, 5'd1, 5'd2, 5'd7);
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", 32'(inst_ready_o), 0);
            tick();
            check("bp_valid", 32'(ex_valid_o), 1);
            check("bp_rd", 32'(rd_o), 5);
            check("bp_alu_op", 32'(alu_op_o), 2);
            check("bp_reg_write", 32'(reg_write_o), 1);
        end
        ex_ready_i = 1'b1;
        #1;
        check("bp_release_ready", 32'(inst_ready_o), 1);
        tick();
        check("addi_rd", 32'(rd_o), 7);
        check("addi_alu_op", 32'(alu_op_o), 3);
        check("addi_alu_src", 32'(alu_src_o), 1);

        // taken branch: two cycles of flush, presented instructions dropped
        br_resolve_i = 1'b1; br_taken_i = 1'b1;
        present(7'b0010011, 5'd1, 5'd2, 5'd9);
        tick();
        check("fl0_busy", 32'(flush_busy_o), 1);
        check("fl0_valid", 32'(ex_valid_o), 0);
        check("fl0_rd", 32'(rd_o), 7);
        br_resolve_i = 1'b0; br_taken_i = 1'b0;
        present(7'b0010011, 5'd1, 5'd2, 5'd10);
        check("fl1_ready", 32'(inst_ready_o), 1);
        tick();
        check("fl1_busy", 32'(flush_busy_o), 1);
        check("fl1_valid", 32'(ex_valid_o), 0);
        check("fl1_rd", 32'(rd_o), 7);
        present(7'b0010011, 5'd1, 5'd2, 5'd11);
        check("fl2_ready", 32'(inst_ready_o), 1);
        tick();
        check("fl2_busy", 32'(flush_busy_o), 0);
        check("fl2_valid", 32'(ex_valid_o), 0);
        check("fl2_rd", 32'(rd_o), 7);
        present(7'b0010011, 5'd1, 5'd2, 5'd12);
        tick();
        check("fl3_valid", 32'(ex_valid_o), 1);
        check("fl3_rd", 32'(rd_o), 12);

        // not-taken resolve is ignored; store decode
        br_resolve_i = 1'b1; br_taken_i = 1'b0;
        present(7'b0100011, 5'd1, 5'd2, 5'd13);
        check("nt_ready", 32'(inst_ready_o), 1);
        tick();
        br_resolve_i = 1'b0;
        check("nt_busy", 32'(flush_busy_o), 0);
        check("sw_valid", 32'(ex_valid_o), 1);
        check("sw_rd", 32'(rd_o), 13);
        check("sw_mem_wr", 32'(mem_wr_o), 1);
        check("sw_imm_sel", 32'(imm_sel_o), 1);
        check("sw_reg_write", 32'(reg_write_o), 0);

        // branch decode
        present(7'b1100011, 5'd1, 5'd2, 5'd14);
        tick();
        check("br_alu_op", 32'(alu_op_o), 1);
        check("br_branch", 32'(branch_o), 1);
        check("br_reg_write", 32'(reg_write_o), 0);
        check("br_mem_wr", 32'(mem_wr_o), 0);

        // unknown opcode
        present(7'b1111111, 5'd1, 5'd2, 5'd15);
        tick();
        check("ill_illegal", 32'(illegal_o), 1);
        check("ill_alu_op", 32'(alu_op_o), 3);
        check("ill_alu_src", 32'(alu_src_o), 1);
        check("ill_reg_write", 32'(reg_write_o), 0);

        // vector opcode, legal only with the feature built in
        present(7'b1010111, 5'd1, 5'd2, 5'd16);
        tick();
`ifdef VECTOR_OP_EN
        check("vec_illegal", 32'(illegal_o), 0);
        check("vec_reg_write", 32'(reg_write_o), 1);
        check("vec_alu_op", 32'(alu_op_o), 0);
        check("vec_alu_src", 32'(alu_src_o), 0);
`else
        check("vec_illegal", 32'(illegal_o), 1);
        check("vec_reg_write", 32'(reg_write_o), 0);
        check("vec_alu_op", 32'(alu_op_o), 3);
`endif

        // load to x0 never creates a hazard
        present(7'b0000011, 5'd1, 5'd2, 5'd0);
        tick();
        present(7'b0110011, 5'd0, 5'd0, 5'd17);
        check("x0_ready", 32'(inst_ready_o), 1);
        tick();
        check("x0_rd", 32'(rd_o), 17);

        // immediate op does not read rs2, so matching rs2 is not a hazard
        present(7'b0000011, 5'd1, 5'd2, 5'd4);
        tick();
        present(7'b0010011, 5'd1, 5'd4, 5'd18);
        check("imm_rs2_ready", 32'(inst_ready_o), 1);
        tick();
        check("imm_rs2_rd", 32'(rd_o), 18);

        // taken branch during flush reloads the counter
        inst_valid_i = 1'b0;
        br_resolve_i = 1'b1; br_taken_i = 1'b1;
        tick();
        tick();
        br_resolve_i = 1'b0; br_taken_i = 1'b0;
        check("rl_busy0", 32'(flush_busy_o), 1);
        tick();
        check("rl_busy1", 32'(flush_busy_o), 1);
        tick();
        check("rl_busy2", 32'(flush_busy_o), 0);

        // reset in the middle of a flush
        present(7'b0010011, 5'd1, 5'd2, 5'd20);
        tick();
        check("pre_rst_rd", 32'(rd_o), 20);
        br_resolve_i = 1'b1; br_taken_i = 1'b1;
        tick();
        br_resolve_i = 1'b0; br_taken_i = 1'b0;
        check("pre_rst_busy", 32'(flush_busy_o), 1);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst_busy", 32'(flush_busy_o), 0);
        check("arst_valid", 32'(ex_valid_o), 0);
        check("arst_rd", 32'(rd_o), 0);
        check("arst_reg_write", 32'(reg_write_o), 0);
        check("arst_alu_op", 32'(alu_op_o), 0);
        check("arst_alu_src", 32'(alu_src_o), 0);
        tick();
        rst_n_i = 1'b1;
        present(7'b0000011, 5'd1, 5'd2, 5'd3);
        check("post_rst_ready", 32'(inst_ready_o), 1);
        check("post_rst_busy", 32'(flush_busy_o), 0);
        tick();
        check("post_rst_valid", 32'(ex_valid_o), 1);
        check("post_rst_rd", 32'(rd_o), 3);
        check("post_rst_mem_rd", 32'(mem_rd_o), 1);
        inst_valid_i = 1'b0;
        tick();
        check("post_rst_no_flush", 32'(flush_busy_o), 0);
        check("post_rst_drain", 32'(ex_valid_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 SHALL have parameter FLUSH_CYC, default 2, number of cycles incoming instructions are discarded after a taken branch (1..15).
REQ-002 SHALL have parameter REG_W, default 5, register-index width.
REQ-003 SHALL have one clock, clk_i, input 1, with all state updated on its rising edge.
REQ-004 SHALL have reset rst_n_i, input 1, asynchronous active-low.
REQ-005 SHALL have inst_valid_i input 1 and inst_ready_o output 1, the decode-side handshake.
REQ-006 SHALL have op_i input 7 (opcode), and rs1_i, rs2_i, rd_i inputs of REG_W each (register indices).
REQ-007 SHALL have ex_valid_o output 1 and ex_ready_i input 1, the execute-side handshake.
REQ-008 SHALL have registered outputs alu_op_o 2, alu_src_o 1, reg_write_o 1, mem_rd_o 1, mem_wr_o 1, mem_to_reg_o 1, branch_o 1, imm_sel_o 1, illegal_o 1, and rd_o REG_W.
REQ-009 SHALL have br_resolve_i input 1 (EX branch resolved this cycle) and br_taken_i input 1 (resolved branch taken).
REQ-010 SHALL have flush_busy_o output 1, high while in FLUSH.

Function
REQ-011 SHALL decode op_i to {alu_op,alu_src,reg_write,mem_rd,mem_wr,mem_to_reg,branch,imm_sel} as follows.
- 0010011: 11,1,1,0,0,0,0,0
- 0110011: 10,0,1,0,0,0,0,0
- 1100011: 01,1,0,0,0,0,1,0
- 0000011: 00,1,1,1,0,1,0,0
- 0100011: 00,1,0,0,1,0,0,1
- all other opcodes: 11,1,0,0,0,0,0,0 with illegal=1; illegal=0 for listed opcodes.
REQ-012 SHALL have FSM states RUN, STALL, FLUSH, with reset state RUN.
REQ-013 SHALL define a load-use hazard when ex_valid_o && mem_rd_o && rd_o!=0 && (rs1_i==rd_o || (op_i uses rs2 && rs2_i==rd_o)); op_i uses rs2 for 0110011, 1100011 and 0100011.
REQ-014 SHALL drive inst_ready_o = (state==FLUSH) || (state==RUN && !hazard && (!ex_valid_o || ex_ready_i)).
REQ-015 SHALL, in RUN with accept (inst_valid_i && inst_ready_o), load the decoded controls and rd_i into the output register and set ex_valid_o=1 the next cycle (latency 1).
REQ-016 SHALL clear ex_valid_o when ex_ready_i is high and no new accept occurs; outputs SHALL hold stable while ex_valid_o && !ex_ready_i.
REQ-017 SHALL, in RUN with inst_valid_i && hazard && ex_ready_i, move to STALL, with ex_valid_o=0 (bubble) the next cycle.
REQ-018 SHALL return from STALL to RUN after exactly one cycle, with the instruction held upstream and re-presented.
REQ-019 SHALL, on br_resolve_i && br_taken_i in any state, enter FLUSH, clear ex_valid_o the next cycle, and load the counter with FLUSH_CYC-1.
REQ-020 SHALL, in FLUSH, accept and discard instructions (no output update), decrement the counter each cycle, and return to RUN on the cycle after the counter reaches 0.
REQ-021 SHALL give a taken branch during FLUSH priority, reloading the counter; flush SHALL override stall and accept in the same cycle.
REQ-022 SHALL ignore br_resolve_i && !br_taken_i, leaving state unchanged.

Reset
REQ-023 SHALL, while rst_n_i=0, immediately force state=RUN, counter=0, ex_valid_o=0, flush_busy_o=0, all control outputs 0, and rd_o=0.
REQ-024 SHALL, on reset asserted mid-STALL or mid-FLUSH, abandon that operation, with no residual flush after release.

Configuration
REQ-025 SHALL use macro VECTOR_OP_EN: when defined, op_i=1010111 SHALL decode to 00,0,1,0,0,0,0,0 with illegal=0 and no rs2 use.
REQ-026 SHALL, when VECTOR_OP_EN is not defined, decode 1010111 as an illegal/default opcode.

Verification
REQ-027 SHALL cover: op_i=0000011, rd_i=3 accepted, ex_ready_i=1 -> next cycle ex_valid_o=1, mem_rd_o=1, mem_to_reg_o=1, reg_write_o=1, alu_op_o=00, rd_o=3.
REQ-028 SHALL cover: lw rd=3 in output, next op 0110011 rs2_i=3 -> inst_ready_o=0, one bubble (ex_valid_o=0), then accept on the following cycle.
REQ-029 SHALL cover: FLUSH_CYC=2, br_resolve_i=br_taken_i=1 -> flush_busy_o=1 for 2 cycles, 2 presented instructions discarded, ex_valid_o=0 throughout, third accepted.
REQ-030 SHALL cover: ex_ready_i=0 for 3 cycles with valid output -> all outputs stable and inst_ready_o=0.
REQ-031 SHALL cover: rst_n_i low mid-FLUSH -> outputs 0 asynchronously, RUN after release, and the first instruction accepted normally.
REQ-032 SHALL cover: op_i=1010111 -> reg_write_o=1, illegal_o=0 with VECTOR_OP_EN defined; illegal_o=1, reg_write_o=0 without it.
